fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the F/D pipeline register. Owns the PC and issues requests to a variable-latency instruction memory over a valid/ready request channel and a valid-only response channel. Buffers returned instructions with their PCs in a small queue. Presents InstrF/PCF/PCPlus4F to the F/D register and handles StallF and branch/jump redirects from Execute.

---
 rtl/fetch_unit.sv | 114 +++++++++++
 tb/tb_fetch_unit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, fetches from a variable-latency imem and queues {pc, instr} for the F/D register.
// Optional FETCH_PERF_CNT_EN adds bubble and redirect performance counters.
module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          QDEPTH    = 2,
   parameter int          MAX_OUTST = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        StallF,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        imem_req_valid_o,
   input  logic        imem_req_ready_i,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rsp_valid_i,
   input  logic [31:0] imem_rsp_data_i,
   output logic [31:0] InstrF_o,
   output logic [31:0] PCF_o,
   output logic [31:0] PCPlus4F_o,
   output logic        FetchValidF_o,
   output logic        FetchBubbleF_o
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_bubble_cnt_o,
   output logic [31:0] perf_redirect_cnt_o
`endif
);
   localparam int AW = $clog2(QDEPTH);
   localparam int CW = AW + 1;
   localparam int DW = 16;
   localparam logic [CW-1:0] QF = QDEPTH[CW-1:0];
   localparam logic [CW:0]   QD = {1'b0, QF};
   localparam logic [CW-1:0] MO = MAX_OUTST[CW-1:0];

   logic [31:0]   pc_q, pc_d;
   logic [31:0]   tag_q  [QDEPTH];
   logic [31:0]   qpc_q  [QDEPTH];
   logic [31:0]   qins_q [QDEPTH];
   logic [AW-1:0] th_q, th_d, tt_q, tt_d, qh_q, qh_d, qt_q, qt_d;
   logic [CW-1:0] tcnt_q, tcnt_d, qcnt_q, qcnt_d;
   logic [DW-1:0] drop_q, drop_d;
   logic          req_fire, rsp_drop, rsp_live, deq;

   // tcnt_q counts only live requests; stale ones after a redirect live in drop_q
   assign imem_req_valid_o = ~rst & ~PCSrcE & (({1'b0, tcnt_q} + {1'b0, qcnt_q}) < QD) & (tcnt_q < MO);
   assign imem_addr_o      = pc_q;
   assign req_fire         = imem_req_valid_o & imem_req_ready_i;
   assign rsp_drop         = imem_rsp_valid_i & (drop_q != '0);
   assign rsp_live         = imem_rsp_valid_i & ~rsp_drop & ~PCSrcE;
   assign deq              = FetchValidF_o & ~StallF & ~PCSrcE;

   always_comb begin
      pc_d   = PCSrcE ? PCTargetE : pc_q + {29'd0, req_fire, 2'd0};
      th_d   = PCSrcE ? '0 : th_q + AW'(rsp_live);
      tt_d   = PCSrcE ? '0 : tt_q + AW'(req_fire);
      tcnt_d = PCSrcE ? '0 : tcnt_q + CW'(req_fire) - CW'(rsp_live);
      qh_d   = PCSrcE ? '0 : qh_q + AW'(deq);
      qt_d   = PCSrcE ? '0 : qt_q + AW'(rsp_live);
      qcnt_d = PCSrcE ? '0 : qcnt_q + CW'(rsp_live) - CW'(deq);
      drop_d = PCSrcE ? drop_q + DW'(tcnt_q) - DW'(imem_rsp_valid_i) : drop_q - DW'(rsp_drop);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= RESET_PC;
         th_q   <= '0;
         tt_q   <= '0;
         tcnt_q <= '0;
         qh_q   <= '0;
         qt_q   <= '0;
         qcnt_q <= '0;
         drop_q <= '0;
      end else begin
         pc_q   <= pc_d;
         th_q   <= th_d;
         tt_q   <= tt_d;
         tcnt_q <= tcnt_d;
         qh_q   <= qh_d;
         qt_q   <= qt_d;
         qcnt_q <= qcnt_d;
         drop_q <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire) tag_q[tt_q] <= pc_q;
      if (rsp_live) begin
         qpc_q[qt_q]  <= tag_q[th_q];
         qins_q[qt_q] <= imem_rsp_data_i;
      end
   end

   always_ff @(posedge clk)
      if (!rst) assert (!(rsp_live && qcnt_q == QF));

   assign FetchValidF_o  = qcnt_q != '0;
   assign FetchBubbleF_o = ~StallF & ~FetchValidF_o;
   assign InstrF_o       = FetchValidF_o ? qins_q[qh_q] : 32'h13;
   assign PCF_o          = FetchValidF_o ? qpc_q[qh_q] : '0;
   assign PCPlus4F_o     = FetchValidF_o ? qpc_q[qh_q] + 32'd4 : '0;

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_bubble_cnt_o   <= '0;
         perf_redirect_cnt_o <= '0;
      end else begin
         perf_bubble_cnt_o   <= perf_bubble_cnt_o + 32'(FetchBubbleF_o);
         perf_redirect_cnt_o <= perf_redirect_cnt_o + 32'(PCSrcE);
      end
   end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven, hand-sequenced and randomized checks of fetch_unit
// against a queue-based reference model and an in-order variable-latency memory.
module tb_fetch_unit;
   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam int QDEPTH = 2;
   localparam int MAX_OUTST = 2;

   logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, pcsrc = 1'b0, ready = 1'b0, rsp_valid = 1'b0;
   logic [31:0] target = '0, rsp_data = '0;
   logic        req_valid, fvalid, bubble;
   logic [31:0] addr, instr, pcf, pcp4;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_bubble, perf_redirect;
`endif

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RPC), .QDEPTH(QDEPTH), .MAX_OUTST(MAX_OUTST)) dut (
      .clk(clk), .rst(rst), .StallF(stall), .PCSrcE(pcsrc), .PCTargetE(target),
      .imem_req_valid_o(req_valid), .imem_req_ready_i(ready), .imem_addr_o(addr),
      .imem_rsp_valid_i(rsp_valid), .imem_rsp_data_i(rsp_data),
      .InstrF_o(instr), .PCF_o(pcf), .PCPlus4F_o(pcp4),
      .FetchValidF_o(fvalid), .FetchBubbleF_o(bubble)
`ifdef FETCH_PERF_CNT_EN
      , .perf_bubble_cnt_o(perf_bubble), .perf_redirect_cnt_o(perf_redirect)
`endif
   );

   typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
   typedef struct { logic [31:0] a; int due; } mreq_t;
   typedef struct { logic st; logic rdy; logic ereq; logic [31:0] eaddr; logic evalid; logic [31:0] epcf; } vec_t;

   ent_t        m_q[$];
   logic [31:0] m_tags[$];
   mreq_t       mem[$];
   logic [31:0] m_pc;
   int          m_drop, lat, cyc;
   int          checks = 0, errors = 0;

   function automatic logic [31:0] word(input logic [31:0] a);
      return a ^ 32'h5A00_0003;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: got no event expected one within the cycle budget (cycle %0d)", name, cyc);
   endtask

   // One clock: drive at negedge, compare against the model, then advance model and memory.
   task automatic cycle(input logic r, input logic st, input logic ps, input logic [31:0] tgt, input logic rdy);
      logic rv, mr, fv;
      logic [31:0] rd;
      ent_t e;
      mreq_t m;
      @(negedge clk);
      rv = mem.size() > 0 && mem[0].due <= cyc;
      rd = rv ? word(mem[0].a) : $urandom;
      rst = r; stall = st; pcsrc = ps; target = tgt; ready = rdy; rsp_valid = rv; rsp_data = rd;
      #1;
      fv = m_q.size() > 0;
      mr = !r && !ps && (m_tags.size() + m_q.size() < QDEPTH) && (m_tags.size() < MAX_OUTST);
      chk("req_valid", req_valid, mr);
      chk("addr", addr, m_pc);
      chk("valid", fvalid, fv);
      chk("instr", instr, fv ? m_q[0].ins : 32'h13);
      chk("pcf", pcf, fv ? m_q[0].pc : 32'h0);
      chk("pcplus4", pcp4, fv ? m_q[0].pc + 32'd4 : 32'h0);
      chk("bubble", bubble, !st && !fv);
      if (rv) void'(mem.pop_front());
      if (r) begin
         m_pc = RPC; m_q.delete(); m_tags.delete(); m_drop = 0; mem.delete();
      end else if (ps) begin
         m_drop = m_drop + m_tags.size() - int'(rv);
         m_pc = tgt; m_q.delete(); m_tags.delete();
      end else begin
         if (fv && !st) void'(m_q.pop_front());
         if (rv) begin
            if (m_drop > 0) m_drop--;
            else begin
               e.pc = m_tags.pop_front(); e.ins = rd; m_q.push_back(e);
            end
         end
         if (mr && rdy) begin
            m_tags.push_back(m_pc);
            m.a = m_pc; m.due = cyc + lat; mem.push_back(m);
            m_pc = m_pc + 32'd4;
         end
      end
      cyc++;
   endtask

   vec_t tbl[23];

   initial begin
      int n;
      logic [31:0] tgt;
      tbl[0]  = '{0, 1, 1, 32'h00, 0, 32'h00};
      tbl[1]  = '{0, 1, 1, 32'h04, 0, 32'h00};
      tbl[2]  = '{0, 1, 0, 32'h08, 1, 32'h00};
      tbl[3]  = '{0, 1, 1, 32'h08, 1, 32'h04};
      tbl[4]  = '{0, 1, 1, 32'h0C, 0, 32'h00};
      tbl[5]  = '{0, 1, 0, 32'h10, 1, 32'h08};
      tbl[6]  = '{0, 1, 1, 32'h10, 1, 32'h0C};
      tbl[7]  = '{0, 1, 1, 32'h14, 0, 32'h00};
      tbl[8]  = '{1, 1, 0, 32'h18, 1, 32'h10};
      tbl[9]  = '{1, 1, 0, 32'h18, 1, 32'h10};
      tbl[10] = '{1, 1, 0, 32'h18, 1, 32'h10};
      tbl[11] = '{0, 1, 0, 32'h18, 1, 32'h10};
      tbl[12] = '{0, 1, 1, 32'h18, 1, 32'h14};
      tbl[13] = '{0, 1, 1, 32'h1C, 0, 32'h00};
      tbl[14] = '{0, 1, 0, 32'h20, 1, 32'h18};
      tbl[15] = '{0, 0, 1, 32'h20, 1, 32'h1C};
      tbl[16] = '{0, 0, 1, 32'h20, 0, 32'h00};
      tbl[17] = '{0, 0, 1, 32'h20, 0, 32'h00};
      tbl[18] = '{0, 0, 1, 32'h20, 0, 32'h00};
      tbl[19] = '{0, 0, 1, 32'h20, 0, 32'h00};
      tbl[20] = '{0, 1, 1, 32'h20, 0, 32'h00};
      tbl[21] = '{0, 1, 1, 32'h24, 0, 32'h00};
      tbl[22] = '{0, 1, 0, 32'h28, 1, 32'h20};

      cyc = 0; lat = 1;
      m_pc = RPC; m_drop = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // reset, streaming, stall with a full queue, memory not ready
      for (int i = 0; i < 23; i++) begin
         cycle(1'b0, tbl[i].st, 1'b0, 32'h0, tbl[i].rdy);
         chk($sformatf("tbl%0d_req", i), req_valid, tbl[i].ereq);
         chk($sformatf("tbl%0d_addr", i), addr, tbl[i].eaddr);
         chk($sformatf("tbl%0d_valid", i), fvalid, tbl[i].evalid);
         chk($sformatf("tbl%0d_pcf", i), pcf, tbl[i].epcf);
      end

      // redirect to 0x100 with two requests in flight, latency 3
      lat = 3; n = 0;
      while (m_tags.size() < 2 && n < 20) begin cycle(0, 0, 0, 0, 1); n++; end
      if (m_tags.size() < 2) timeout("redir_setup");
      cycle(0, 0, 1, 32'h100, 1);
      n = 0;
      do begin cycle(0, 0, 0, 0, 1); n++; end while (!fvalid && n < 20);
      if (!fvalid) timeout("redir_first");
      chk("redir_pc0", pcf, 32'h100);
      chk("redir_instr0", instr, word(32'h100));
      n = 0;
      do begin cycle(0, 0, 0, 0, 1); n++; end while (!fvalid && n < 20);
      chk("redir_pc1", pcf, 32'h104);

      // redirect coinciding with a response and a consume
      lat = 1; n = 0;
      while (!(m_q.size() > 0 && mem.size() > 0 && mem[0].due <= cyc) && n < 20) begin cycle(0, 0, 0, 0, 1); n++; end
      if (!(m_q.size() > 0 && mem.size() > 0)) timeout("flush_setup");
      cycle(0, 0, 1, 32'h200, 1);
      cycle(0, 0, 0, 0, 1);
      chk("flush_empty", fvalid, 1'b0);
      n = 0;
      while (!fvalid && n < 20) begin cycle(0, 0, 0, 0, 1); n++; end
      if (!fvalid) timeout("flush_first");
      chk("flush_pc0", pcf, 32'h200);

      // reset mid-stream with two outstanding
      lat = 3; n = 0;
      while (m_tags.size() < 2 && n < 20) begin cycle(0, 0, 0, 0, 1); n++; end
      if (m_tags.size() < 2) timeout("rst_setup");
      cycle(1, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      chk("rst_valid", fvalid, 1'b0);
      chk("rst_pcf", pcf, 32'h0);
      chk("rst_pcp4", pcp4, 32'h0);
      chk("rst_instr", instr, 32'h13);
      chk("rst_req", req_valid, 1'b1);
      chk("rst_addr", addr, RPC);

      // randomized traffic including wrap-around targets
      for (int i = 0; i < 3000; i++) begin
         lat = $urandom_range(1, 4);
         tgt = ($urandom % 4 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
         cycle(($urandom % 500) == 0, ($urandom % 10) < 3, ($urandom % 32) == 0, tgt, ($urandom % 10) < 7);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
